// File: rtl/store_unit_pkg.sv
// Shared types and constants for the store path: funct3 codes, FSM states and
// the registered DMEM beat.
package store_unit_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   // Wide enough for any word index taken from a 32-bit byte address.
   localparam int unsigned BEAT_ADDR_W = 30;

   typedef enum logic [1:0] {
      StIdle,
      StLo,
      StHi,
      StErr
   } state_e;

   typedef struct packed {
      logic [BEAT_ADDR_W-1:0] addr;
      logic [3:0]             we;
      logic [31:0]            wdata;
   } beat_t;

endpackage

// File: rtl/store_unit_if.sv
// Request handshake plus DMEM write port of the store unit, bundled as one interface.
interface store_unit_if #(
   parameter int unsigned DMEM_ADDR_WIDTH = 12
);

   logic                       req_valid;
   logic                       req_ready;
   logic [31:0]                req_addr;
   logic [31:0]                req_data;
   logic [2:0]                 req_funct3;
   logic                       mem_en;
   logic [3:0]                 mem_we;
   logic [DMEM_ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]                mem_wdata;
   logic                       done;
   logic                       err;

   modport master (
      output req_valid, req_addr, req_data, req_funct3,
      input  req_ready, mem_en, mem_we, mem_addr, mem_wdata, done, err
   );

   modport slave (
      input  req_valid, req_addr, req_data, req_funct3,
      output req_ready, mem_en, mem_we, mem_addr, mem_wdata, done, err
   );

endinterface

// File: rtl/store_lane_align.sv
// Combinational lane alignment: byte mask and data shifted into a two-word window
// according to the store size and byte offset.
module store_lane_align
   import store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] data,
   output logic [7:0]  mask8,
   output logic [63:0] data64,
   output logic        legal
);

   logic [3:0] size_mask;

   always_comb begin
      size_mask = 4'h0;
      legal     = 1'b1;
      case (funct3)
         F3_SB:   size_mask = 4'h1;
         F3_SH:   size_mask = 4'h3;
         F3_SW:   size_mask = 4'hF;
         default: legal = 1'b0;
      endcase
      mask8  = {4'h0, size_mask} << off;
      data64 = {32'h0, data} << {off, 3'b000};
   end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts a store, drives one or two aligned DMEM word writes and
// pulses done on the final beat (err instead for an illegal funct3).
module store_unit
   import store_unit_pkg::*;
#(
   parameter int unsigned DMEM_ADDR_WIDTH = 12
) (
   input logic         clk,
   input logic         rst_n,
   store_unit_if.slave bus
);

   state_e state_q, state_d;
   logic   pend_q, pend_d;
   beat_t  hi_q, hi_d;
   beat_t  beat_q, beat_d;
   logic   en_q, en_d;
   logic   done_q, done_d;
   logic   err_q, err_d;

   logic [7:0]                 mask8;
   logic [63:0]                data64;
   logic                       legal;
   logic                       accept;
   logic [DMEM_ADDR_WIDTH-1:0] w, w_inc;

   store_lane_align u_align (
      .funct3 (bus.req_funct3),
      .off    (bus.req_addr[1:0]),
      .data   (bus.req_data),
      .mask8  (mask8),
      .data64 (data64),
      .legal  (legal)
   );

   assign w     = bus.req_addr[DMEM_ADDR_WIDTH+1:2];
   assign w_inc = w + DMEM_ADDR_WIDTH'(1);

   // Only the first beat of a split store blocks new requests.
   assign bus.req_ready = (state_q == StIdle) || (state_q == StLo && !pend_q) ||
                          (state_q == StHi) || (state_q == StErr);
   assign accept = bus.req_valid && bus.req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = StIdle;
      if (state_q == StLo && pend_q) begin
         state_d = StHi;
      end else if (accept) begin
         state_d = legal ? StLo : StErr;
      end
   end

   always_comb begin
      pend_d = accept && legal && (mask8[7:4] != 4'h0);
      hi_d   = hi_q;
      if (accept) begin
         hi_d = '{addr: BEAT_ADDR_W'(w_inc), we: mask8[7:4], wdata: data64[63:32]};
      end
      en_d   = 1'b0;
      done_d = 1'b0;
      err_d  = 1'b0;
      beat_d = '0;
      unique case (state_d)
         StLo: begin
            en_d   = 1'b1;
            done_d = !pend_d;
            beat_d = '{addr: BEAT_ADDR_W'(w), we: mask8[3:0], wdata: data64[31:0]};
         end
         StHi: begin
            en_d   = 1'b1;
            done_d = 1'b1;
            beat_d = hi_q;
         end
         StErr:   err_d = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= 1'b0;
         hi_q   <= '0;
         beat_q <= '0;
         en_q   <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         hi_q   <= hi_d;
         beat_q <= beat_d;
         en_q   <= en_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign bus.mem_en    = en_q;
   assign bus.mem_we    = beat_q.we;
   assign bus.mem_addr  = beat_q.addr[DMEM_ADDR_WIDTH-1:0];
   assign bus.mem_wdata = beat_q.wdata;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

   logic unused_bits;
   assign unused_bits = ^{beat_q.addr[BEAT_ADDR_W-1:DMEM_ADDR_WIDTH],
                          bus.req_addr[31:DMEM_ADDR_WIDTH+2]};

endmodule

// File: doc/store_unit.md
# store_unit

Store-path counterpart to the load write-back stage: accepts a store request (byte address from the ALU, rs2 data, funct3), aligns the data onto the 32-bit data-memory lanes and generates per-byte write enables. It drives the DMEM write port directly. Stores whose bytes cross a word boundary are split into two sequential word writes. It sits between the execute/memory pipeline stage and the DMEM write port.

## Interface

Parameters:
- DMEM_ADDR_WIDTH, 12: width of the DMEM word index; word addresses wrap modulo 2^DMEM_ADDR_WIDTH.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  store request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_addr  in  32  byte address, from the ALU result.
- req_data  in  32  store data (rs2), right-justified.
- req_funct3  in  3  000 SB, 001 SH, 010 SW; all other values are illegal.
- mem_en  out  1  DMEM port enable for this beat.
- mem_we  out  4  byte write enables; bit i writes byte lane i, bits [8i+7:8i].
- mem_addr  out  DMEM_ADDR_WIDTH  word index.
- mem_wdata  out  32  lane-aligned write data.
- done  out  1  one-cycle pulse when the final beat of a store is driven.
- err  out  1  one-cycle pulse for an illegal funct3.

## Operation

- Handshake: a request is accepted when req_valid && req_ready. Inputs are sampled only on acceptance.
- Alignment, computed on the accepted request:
  - off = req_addr[1:0].
  - size mask: SB = 0x01, SH = 0x03, SW = 0x0F.
  - 8-bit mask8 = size mask << off.
  - 64-bit data64 = zero-extended req_data << 8*off.
  - word index w = req_addr[DMEM_ADDR_WIDTH+1:2].
- Low beat: mem_addr = w, mem_we = mask8[3:0], mem_wdata = data64[31:0].
- High beat: issued only if mask8[7:4] != 0. It drives mem_addr = w+1 (wrapping), mem_we = mask8[7:4], mem_wdata = data64[63:32].
- Unwritten lanes of mem_wdata are don't-care, but they are driven from data64 deterministically.
- State machine:
  - IDLE: no beat driven.
    - On accept with legal funct3 -> LO.
    - On accept with illegal funct3 -> ERR.
  - LO: low beat driven.
    - If a split is pending -> HI.
    - Otherwise, on a new accept -> LO or ERR; with no accept -> IDLE.
  - HI: high beat driven. Then -> LO or ERR on a new accept, otherwise -> IDLE.
  - ERR: err = 1, mem_en = 0, done = 0. Then -> LO or ERR on a new accept, otherwise -> IDLE.
- req_ready = (state == IDLE) || (state == LO && !split_pending) || state == HI || state == ERR. It is combinational from registered state; stalls occur only during a split.
- mem_we is all-zero whenever mem_en = 0.

## Timing

- All outputs are registered except req_ready.
- Reset values: state IDLE, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, done 0, err 0. req_ready reads 1 once rst_n deasserts.
- Latency: a request accepted in cycle N drives its low beat in N+1.
  - Split: the high beat is driven in N+2, and req_ready = 0 during N+1.
  - done is high in the cycle of the final beat (N+1, or N+2 if split).
- Throughput: one aligned or non-crossing store per cycle; a split store costs 2 cycles.
- Wrap: w = 2^DMEM_ADDR_WIDTH - 1 with a split sends the high beat to word 0.
- Illegal funct3: err pulses in N+1; no DMEM activity occurs for that request.
- Reset asserted mid-split: all outputs clear asynchronously. The pending high beat is discarded, not replayed.
- req_valid low while ready: no state change except the LO/HI/ERR -> IDLE transition.

## Structure

- Shared package holds:
  - store funct3 constants (F3_SB, F3_SH, F3_SW)
  - state enum (IDLE, LO, HI, ERR)
  - a beat struct {addr, we, wdata}
- Natural sub-module: store_lane_align. It is purely combinational: funct3, off and req_data in; mask8, data64 and a legal flag out. Unit-test it separately.
- The FSM, the pending-high-beat register and the output registers live in store_unit.

## Test plan

- SW, addr 0x100, data 0xDEADBEEF -> one beat: mem_addr 0x40, we 0xF, wdata 0xDEADBEEF, done in the same cycle.
- SB, addr 0x103, data 0x000000A5 -> one beat: mem_addr 0x40, we 0x8, wdata[31:24] = 0xA5.
- SH, addr 0x103, data 0x1234 -> two beats:
  - word 0x40, we 0x8, byte 0x34;
  - word 0x41, we 0x1, byte 0x12;
  - req_ready low in the first beat; done only on the second.
- SW, addr 0x3FFE (DMEM_ADDR_WIDTH 12), data 0xAABBCCDD -> word 0xFFF with we 0xC, lanes 3:2 = 0xCCDD; then word 0x000 with we 0x3, lanes 1:0 = 0xAABB.
- funct3 = 011, then SW back-to-back with SB -> err pulse with no mem_en; then two consecutive beats with no bubble and two done pulses.
- Reset asserted during the first beat of a split SH -> outputs zero immediately and no high beat after release; a new SW after reset completes normally.
